// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the load/store unit. One transaction is in flight at a time. Data wins
// over fetch, except after MAX_DATA_STREAK consecutive data wins taken while a
// fetch was waiting. A response that never arrives is ended by a timeout,
// which returns an error response.
module mem_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_err_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic                  owner_lsu;
  logic [SW-1:0]         streak;
  logic [TW-1:0]         tcnt;
  logic                  cap_we;
  logic [BW-1:0]         cap_be;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic in_req, in_resp, timeout_hit, resp_done, arb_en;
  logic lsu_win, if_win, streak_full;

  assign in_req      = (state == S_REQ);
  assign in_resp     = (state == S_RESP);
  // Last allowed wait cycle reached with no response; never fires when TIMEOUT_CYCLES is 0.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_resp && !mem_rvalid_i &&
                       (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign resp_done   = in_resp && (mem_rvalid_i || timeout_hit);
  // Arbitrate when idle, or in the cycle the current response completes.
  // Any state other than REQ/RESP behaves as idle.
  assign arb_en      = !in_req && (!in_resp || resp_done);

  assign streak_full = (streak == SW'(MAX_DATA_STREAK));
  assign lsu_win     = lsu_req_i && !(if_req_i && streak_full);
  assign if_win      = if_req_i && !lsu_win;

  // Request side: captured fields are only presented while in REQ.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & cap_we;
  assign mem_be_o    = in_req ? cap_be    : '0;
  assign mem_addr_o  = in_req ? cap_addr  : '0;
  assign mem_wdata_o = in_req ? cap_wdata : '0;
  assign if_gnt_o    = in_req & mem_gnt_i & ~owner_lsu;
  assign lsu_gnt_o   = in_req & mem_gnt_i &  owner_lsu;

  // Response side: only the owner sees rvalid/rdata/err; a timeout returns zero data.
  assign if_rvalid_o  = resp_done & ~owner_lsu;
  assign lsu_rvalid_o = resp_done &  owner_lsu;
  assign if_err_o     = timeout_hit & ~owner_lsu;
  assign lsu_err_o    = timeout_hit &  owner_lsu;
  assign if_rdata_o   = (in_resp && mem_rvalid_i && !owner_lsu) ? mem_rdata_i : '0;
  assign lsu_rdata_o  = (in_resp && mem_rvalid_i &&  owner_lsu) ? mem_rdata_i : '0;
  assign busy_o       = (state != S_IDLE);

  // FSM, arbitration/capture, fetch starvation streak and response timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_lsu <= 1'b0;
      streak    <= '0;
      tcnt      <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (arb_en) begin
      if (lsu_win) begin
        state     <= S_REQ;
        owner_lsu <= 1'b1;
        cap_we    <= lsu_we_i;
        cap_be    <= lsu_be_i;
        cap_addr  <= lsu_addr_i;
        cap_wdata <= lsu_wdata_i;
        if (if_req_i && !streak_full) streak <= streak + SW'(1);
      end else if (if_win) begin
        state     <= S_REQ;
        owner_lsu <= 1'b0;
        cap_we    <= 1'b0;
        cap_be    <= '1;
        cap_addr  <= if_addr_i;
        cap_wdata <= '0;
        streak    <= '0;
      end else begin
        state <= S_IDLE;
      end
    end else if (in_req) begin
      if (mem_gnt_i) begin
        state <= S_RESP;
        tcnt  <= '0;
      end
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch path (PC) and the load/store unit, so instruction and data memory can be unified.
- Sits between the program counter/LSU and the memory; the core stalls while its request is not granted or has no response yet.
- Runs one outstanding transaction at a time, with fixed data-over-fetch priority, a starvation limit for fetch and a response timeout.

Parameters:
DATA_WIDTH, 32, data bus width; must be a multiple of 8
ADDR_WIDTH, 32, address width
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is pending; must be >= 1
TIMEOUT_CYCLES, 16, cycles waiting for rvalid before an error response; 0 disables

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req_i  in  1  fetch request; held until if_gnt_o
if_addr_i  in  ADDR_WIDTH  fetch address
if_gnt_o  out  1  fetch request accepted by memory
if_rvalid_o  out  1  fetch response valid
if_rdata_o  out  DATA_WIDTH  fetch read data
if_err_o  out  1  fetch response is a timeout error
lsu_req_i  in  1  data request; held until lsu_gnt_o
lsu_we_i  in  1  1 store, 0 load
lsu_be_i  in  DATA_WIDTH/8  byte enables
lsu_addr_i  in  ADDR_WIDTH  data address
lsu_wdata_i  in  DATA_WIDTH  store data
lsu_gnt_o  out  1  data request accepted
lsu_rvalid_o  out  1  data response valid (loads and stores)
lsu_rdata_o  out  DATA_WIDTH  load data
lsu_err_o  out  1  data response is a timeout error
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE; owner=IF; streak=0; timeout counter=0.
  - All outputs 0.
  - A reset mid-transaction abandons it; no rvalid is issued to either requester.
- FSM states are IDLE, REQ and RESP. Registers: owner (IF/LSU), captured we/be/addr/wdata.
- Arbitration (IDLE, or RESP in its completion cycle):
  - Only LSU requests -> LSU wins. Only IF requests -> IF wins.
  - Both request -> LSU wins, unless streak==MAX_DATA_STREAK, in which case IF wins.
  - Winner's fields are captured; next state is REQ. No request -> IDLE.
  - For a fetch, captured values are we=0 and be=all ones; mem_wdata_o is driven 0.
- streak:
  - +1 when LSU wins while if_req_i=1, saturating at MAX_DATA_STREAK.
  - Cleared when IF wins.
  - Unchanged when LSU wins with if_req_i=0.
- REQ:
  - mem_req_o=1 and mem_* driven from the captured registers, stable until grant.
  - On mem_gnt_i=1, the owner's gnt_o=1 for exactly that cycle; next state RESP; timeout counter cleared.
  - gnt_o is never asserted outside REQ.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i=1: the owner's rvalid_o=1 and rdata_o=mem_rdata_i (combinational) for that cycle, err_o=0; then arbitrate.
  - Otherwise the counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without rvalid: owner rvalid_o=1, err_o=1, rdata_o=0; then arbitrate.
- Non-owner rvalid/rdata/err are 0 at all times.
- mem_rvalid_i in IDLE/REQ (late response after a timeout) is dropped silently.
- Latency:
  - Request seen in IDLE at cycle N -> mem_req_o at N+1.
  - With same-cycle grant, gnt_o at N+1 and earliest rvalid_o at N+2.
  - Back-to-back throughput: one transaction per 2 cycles.

Test Plan:
- Fetch only, if_addr=0x100, gnt immediate, rvalid 1 cycle after grant with 0x00500093 -> mem_addr_o=0x100, we=0, be=4'hF at N+1, if_gnt_o at N+1, if_rvalid_o with 0x00500093 at N+2; LSU outputs 0.
- Both request in the same cycle; LSU store addr 0x2000, wdata 0xDEADBEEF, be=4'b0011 -> LSU transaction first with exact fields, lsu_rvalid_o=1; fetch granted in the following REQ.
- lsu_req_i and if_req_i held high continuously, MAX_DATA_STREAK=4 -> grant order L,L,L,L,I,L,L,L,L,I.
- mem_gnt_i low for 3 cycles -> mem_req_o and fields stable for 4 cycles, if_gnt_o high only in the grant cycle.
- TIMEOUT_CYCLES=8, no rvalid -> lsu_rvalid_o=1, lsu_err_o=1, lsu_rdata_o=0 in the 8th RESP cycle; a later mem_rvalid_i in IDLE produces no output.
- rst asserted during RESP -> next cycle all outputs 0, busy_o=0; a subsequent mem_rvalid_i is ignored.
